// File: rtl/rriot_bus_initiator.sv
// rriot_bus_initiator
//
// Bus master for the RRIOT peripheral bus. Accepts one host command at a time
// over a valid/ready channel and turns it into a single read or write cycle on
// the peripheral's A / we_n / DI / RS_n / CS lines. The result comes back on a
// response channel that holds until the host accepts it. All logic runs on the
// rising edge of phi2, which is the peripheral's clock domain. Every output is
// registered.
//
// Parameters
//   RD_LATENCY      clock edges from address presented to peripheral DO valid (1..15)
//   TIMEOUT_CYCLES  read timeout in cycles, only used when RRIOT_INIT_TIMEOUT_EN
//                   is defined (RD_LATENCY+1..255)
//
// Optional feature macro: RRIOT_INIT_TIMEOUT_EN
//   defined   : a read waits for bus_oe at or after the nominal sample edge, and
//               gives up after TIMEOUT_CYCLES with rsp_err=1, rsp_rdata=0xFF
//   undefined : a read samples at the fixed edge, rsp_err is tied low
//
// Ports
//   phi2        in   clock
//   rst_n       in   synchronous active-low reset
//   cmd_valid   in   host command valid
//   cmd_ready   out  initiator can accept a command (IDLE only)
//   cmd_we      in   1=write, 0=read
//   cmd_addr    in   [9:0] peripheral address
//   cmd_wdata   in   [7:0] write data
//   cmd_rom     in   1=ROM access (drives bus_rs_n low)
//   rsp_valid   out  response valid
//   rsp_ready   in   host accepts response
//   rsp_rdata   out  [7:0] read data (0x00 for writes)
//   rsp_err     out  read timed out
//   bus_a       out  [9:0] peripheral address
//   bus_we_n    out  peripheral write enable, active low
//   bus_wdata   out  [7:0] peripheral DI
//   bus_rdata   in   [7:0] peripheral DO
//   bus_oe      in   peripheral OE
//   bus_rs_n    out  peripheral RS_n
//   bus_cs1_n   out  chip select, active low

module rriot_bus_initiator #(
    parameter int RD_LATENCY     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic [9:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_rom,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [9:0] bus_a,
    output logic       bus_we_n,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_oe,
    output logic       bus_rs_n,
    output logic       bus_cs1_n
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);

    state_t     state;
    logic       lat_we;
    logic [3:0] lat_cnt;
    logic       sample_now;
    logic       timed_out;

`ifdef RRIOT_INIT_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;

    // Sample on the first edge at or after the nominal one where the
    // peripheral actually drives DO; give up once the timeout window is spent.
    assign sample_now = (lat_cnt >= RD_LAT) && bus_oe;
    assign timed_out  = !sample_now && (tmo_cnt == TMO_LAST);
`else
    localparam logic [7:0] UNUSED_TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic unused_oe;

    // Fixed-latency read: DO is trusted on the RD_LATENCY+1-th edge.
    assign sample_now = (lat_cnt == RD_LAT);
    assign timed_out  = 1'b0;
    assign unused_oe  = bus_oe ^ UNUSED_TIMEOUT[0];
    assign rsp_err    = 1'b0;
`endif

    // Single-process FSM. The bus lines are set up on the accepting edge, so
    // they are already valid in the first ACCESS cycle. A write therefore
    // occupies the bus for exactly one cycle. A read keeps the address up
    // until the sampling edge.
    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_cnt   <= 4'd0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            bus_a     <= 10'd0;
            bus_we_n  <= 1'b1;
            bus_wdata <= 8'h00;
            bus_rs_n  <= 1'b1;
            bus_cs1_n <= 1'b1;
`ifdef RRIOT_INIT_TIMEOUT_EN
            tmo_cnt   <= 8'd0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= ACCESS;
                        cmd_ready <= 1'b0;
                        lat_we    <= cmd_we;
                        lat_cnt   <= 4'd0;
                        bus_a     <= cmd_addr;
                        bus_we_n  <= ~cmd_we;
                        bus_wdata <= cmd_we ? cmd_wdata : 8'h00;
                        bus_rs_n  <= ~cmd_rom;
                        bus_cs1_n <= 1'b0;
`ifdef RRIOT_INIT_TIMEOUT_EN
                        tmo_cnt   <= 8'd0;
`endif
                    end
                end

                ACCESS: begin
                    if (lat_we || sample_now || timed_out) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= lat_we    ? 8'h00 :
                                     timed_out ? 8'hFF : bus_rdata;
                        bus_a     <= 10'd0;
                        bus_we_n  <= 1'b1;
                        bus_wdata <= 8'h00;
                        bus_rs_n  <= 1'b1;
                        bus_cs1_n <= 1'b1;
`ifdef RRIOT_INIT_TIMEOUT_EN
                        rsp_err   <= !lat_we && timed_out;
`endif
                    end else begin
                        // Saturating counters: a long wait never wraps back
                        // to an early sample point.
                        if (lat_cnt != 4'hF) begin
                            lat_cnt <= lat_cnt + 4'd1;
                        end
`ifdef RRIOT_INIT_TIMEOUT_EN
                        if (tmo_cnt != 8'hFF) begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
`endif
                    end
                end

                RESP: begin
                    // Response is held stable until accepted. cmd_ready only
                    // rises after the handshake edge, so a command offered in
                    // the handshake cycle is not taken.
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 8'h00;
                        cmd_ready <= 1'b1;
`ifdef RRIOT_INIT_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rriot_bus_initiator.sv
// tb_rriot_bus_initiator
//
// Self-checking bench for rriot_bus_initiator in its default build (fixed read
// latency, no timeout). A small peripheral model holds a 1 KiB memory that is
// preloaded with addr[7:0] ^ 0x3C. Writes land in the memory, and reads return
// the memory contents two edges after the address appears. A table of command
// vectors is followed by hand-written backpressure and reset-mid-read sequences.

module tb_rriot_bus_initiator;

    logic       phi2;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [9:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       cmd_rom;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [9:0] bus_a;
    logic       bus_we_n;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_oe;
    logic       bus_rs_n;
    logic       bus_cs1_n;

    int checks;
    int failures;

    rriot_bus_initiator #(
        .RD_LATENCY    (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .phi2     (phi2),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_rom  (cmd_rom),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .bus_a    (bus_a),
        .bus_we_n (bus_we_n),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_oe   (bus_oe),
        .bus_rs_n (bus_rs_n),
        .bus_cs1_n(bus_cs1_n)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    // Peripheral model: writes are captured while selected. Read data is
    // delayed through two registers, so DO becomes valid two edges after the
    // address is presented.
    logic [7:0] mem [1024];
    logic [7:0] rd_pipe;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'(i) ^ 8'h3C;
        end
    end

    always @(posedge phi2) begin
        if (!bus_cs1_n && !bus_we_n) begin
            mem[bus_a] <= bus_wdata;
        end
        rd_pipe   <= mem[bus_a];
        bus_rdata <= rd_pipe;
    end

    assign bus_oe = 1'b1;

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic       rom;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkBusIdle(input string name);
        checkOutput({name, " bus idle"},
                    {bus_a, bus_we_n, bus_wdata, bus_rs_n, bus_cs1_n},
                    {10'd0, 1'b1, 8'h00, 1'b1, 1'b1});
    endtask

    // Runs one command from the table. Cycle N is the cycle cmd_valid is
    // presented, and cycles are counted until rsp_valid appears.
    task automatic applyStimulus(input vec_t v, input int idx);
        int    cycles;
        int    held;
        string tag;
        tag    = $sformatf("vec%0d", idx);
        cycles = 0;
        while (!cmd_ready && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput({tag, " cmd_ready before issue"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_rom   = v.rom;
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = 8'h00;
        cycles    = 1;
        checkOutput({tag, " access lines"},
                    {bus_a, bus_we_n, bus_wdata, bus_rs_n, bus_cs1_n, cmd_ready},
                    {v.addr, ~v.we, (v.we ? v.wdata : 8'h00), ~v.rom, 1'b0, 1'b0});
        held = 0;
        while (!rsp_valid && cycles < 40) begin
            if (!bus_cs1_n && bus_a == v.addr) held++;
            tick();
            cycles++;
        end
        checkOutput({tag, " rsp latency"}, 32'(cycles), 32'(v.exp_lat));
        checkOutput({tag, " address held cycles"}, 32'(held), 32'(v.exp_lat - 1));
        checkOutput({tag, " rsp data/err"}, {rsp_rdata, rsp_err}, {v.exp_rdata, 1'b0});
        checkBusIdle({tag, " resp"});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput({tag, " after handshake"}, {rsp_valid, cmd_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        int seen;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 10'd0;
        cmd_wdata = 8'h00;
        cmd_rom   = 1'b0;
        rsp_ready = 1'b0;

        vecs[0] = '{1'b1, 10'h201, 8'hA5, 1'b0, 8'h00, 2};
        vecs[1] = '{1'b0, 10'h200, 8'h00, 1'b0, 8'h3C, 4};
        vecs[2] = '{1'b0, 10'h201, 8'h00, 1'b0, 8'hA5, 4};
        vecs[3] = '{1'b0, 10'h3FF, 8'h00, 1'b1, 8'hC3, 4};
        vecs[4] = '{1'b1, 10'h000, 8'h5A, 1'b1, 8'h00, 2};
        vecs[5] = '{1'b0, 10'h000, 8'h00, 1'b0, 8'h5A, 4};
        vecs[6] = '{1'b1, 10'h3FF, 8'h00, 1'b0, 8'h00, 2};
        vecs[7] = '{1'b0, 10'h3FF, 8'h00, 1'b0, 8'h00, 4};
        vecs[8] = '{1'b0, 10'h155, 8'h00, 1'b0, 8'h69, 4};

        // Reset held for two cycles.
        tick();
        tick();
        checkOutput("reset rsp/cmd_ready", {rsp_valid, rsp_rdata, rsp_err, cmd_ready},
                    {1'b0, 8'h00, 1'b0, 1'b1});
        checkBusIdle("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Backpressure: read 0x200, hold rsp_ready low for 5 cycles while a
        // write command is offered, which must be ignored.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 10'h200;
        cmd_rom   = 1'b0;
        tick();
        cmd_we    = 1'b1;
        cmd_addr  = 10'h123;
        cmd_wdata = 8'hEE;
        seen = 0;
        while (!rsp_valid && seen < 20) begin
            tick();
            seen++;
        end
        checkOutput("bp rsp latency", 32'(seen + 1), 32'd4);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("bp hold %0d", c), {rsp_valid, rsp_rdata, cmd_ready},
                        {1'b1, 8'h3C, 1'b0});
            checkBusIdle($sformatf("bp hold %0d", c));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("bp release", {rsp_valid, cmd_ready, bus_cs1_n}, {1'b0, 1'b1, 1'b1});
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        tick();
        checkOutput("bp ignored write kept out of memory", 32'(mem[10'h123]), 32'(8'h1F));

        // Reset in cycle N+2 of a read: no response may ever appear.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 10'h2AA;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("mid-read reset state", {rsp_valid, cmd_ready}, {1'b0, 1'b1});
        checkBusIdle("mid-read reset");
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rsp_valid) seen++;
        end
        checkOutput("mid-read reset no response", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
